// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter/sequencer that serialises two valid/ready requesters onto
// a single-port 16x32 memory and returns per-requester responses with error flag.
module mem_access_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_wr,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rsp_data,
    output logic              a_rsp_err,
    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_wr,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rsp_data,
    output logic              b_rsp_err,
    output logic              mem_EN,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_add,
    output logic [DATA_W-1:0] mem_Data_in,
    input  logic              mem_valid_out,
    input  logic [DATA_W-1:0] mem_Data_out,
    output logic              busy,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_CAPT, ST_RESP} state_t;

    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    state_t              state_r;
    logic                ptr_b_r;
    logic                owner_b_r;
    logic                op_wr_r;
    logic [1:0]          lat_cnt_r;
    logic                mem_en_r;
    logic                mem_wr_en_r;
    logic                mem_rd_en_r;
    logic [ADDR_W-1:0]   mem_add_r;
    logic [DATA_W-1:0]   mem_data_in_r;
    logic                a_rsp_valid_r;
    logic [DATA_W-1:0]   a_rsp_data_r;
    logic                a_rsp_err_r;
    logic                b_rsp_valid_r;
    logic [DATA_W-1:0]   b_rsp_data_r;
    logic                b_rsp_err_r;
    logic [CNT_W-1:0]    wr_cnt_r;
    logic [CNT_W-1:0]    rd_cnt_r;
    logic [CNT_W-1:0]    err_cnt_r;

    logic                grant_a_s;
    logic                grant_b_s;
    logic                sel_wr_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic [DATA_W-1:0]   rd_data_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Grant selection: a lone valid port wins, otherwise the pointer port wins.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (a_req_valid && (!b_req_valid || !ptr_b_r)) begin
                grant_a_s = 1'b1;
            end else if (b_req_valid) begin
                grant_b_s = 1'b1;
            end else begin
                grant_a_s = 1'b0;
                grant_b_s = 1'b0;
            end
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    assign sel_wr_s    = grant_b_s ? b_req_wr    : a_req_wr;
    assign sel_addr_s  = grant_b_s ? b_req_addr  : a_req_addr;
    assign sel_wdata_s = grant_b_s ? b_req_wdata : a_req_wdata;
    assign rd_data_s   = mem_valid_out ? mem_Data_out : {DATA_W{1'b0}};

    // Sequencer FSM with registered memory command, responses and statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            ptr_b_r       <= 1'b0;
            owner_b_r     <= 1'b0;
            op_wr_r       <= 1'b0;
            lat_cnt_r     <= 2'd0;
            mem_en_r      <= 1'b0;
            mem_wr_en_r   <= 1'b0;
            mem_rd_en_r   <= 1'b0;
            mem_add_r     <= {ADDR_W{1'b0}};
            mem_data_in_r <= {DATA_W{1'b0}};
            a_rsp_valid_r <= 1'b0;
            a_rsp_data_r  <= {DATA_W{1'b0}};
            a_rsp_err_r   <= 1'b0;
            b_rsp_valid_r <= 1'b0;
            b_rsp_data_r  <= {DATA_W{1'b0}};
            b_rsp_err_r   <= 1'b0;
            wr_cnt_r      <= {CNT_W{1'b0}};
            rd_cnt_r      <= {CNT_W{1'b0}};
            err_cnt_r     <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_a_s || grant_b_s) begin
                        owner_b_r     <= grant_b_s;
                        op_wr_r       <= sel_wr_s;
                        ptr_b_r       <= ~grant_b_s;
                        mem_add_r     <= sel_addr_s;
                        mem_data_in_r <= sel_wdata_s;
                        // The memory pins are inverted: rd_en strobes a write, wr_en a read.
                        mem_en_r      <= 1'b1;
                        mem_wr_en_r   <= ~sel_wr_s;
                        mem_rd_en_r   <= sel_wr_s;
                        state_r       <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    mem_en_r    <= 1'b0;
                    mem_wr_en_r <= 1'b0;
                    mem_rd_en_r <= 1'b0;
                    if (op_wr_r) begin
                        a_rsp_valid_r <= ~owner_b_r;
                        b_rsp_valid_r <= owner_b_r;
                        a_rsp_data_r  <= {DATA_W{1'b0}};
                        b_rsp_data_r  <= {DATA_W{1'b0}};
                        a_rsp_err_r   <= 1'b0;
                        b_rsp_err_r   <= 1'b0;
                        wr_cnt_r      <= sat_inc(wr_cnt_r);
                        state_r       <= ST_RESP;
                    end else begin
                        lat_cnt_r <= LAT_LOAD;
                        state_r   <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    if (lat_cnt_r == 2'd0) begin
                        a_rsp_valid_r <= ~owner_b_r;
                        b_rsp_valid_r <= owner_b_r;
                        a_rsp_data_r  <= owner_b_r ? {DATA_W{1'b0}} : rd_data_s;
                        b_rsp_data_r  <= owner_b_r ? rd_data_s : {DATA_W{1'b0}};
                        a_rsp_err_r   <= ~owner_b_r & ~mem_valid_out;
                        b_rsp_err_r   <= owner_b_r & ~mem_valid_out;
                        rd_cnt_r      <= sat_inc(rd_cnt_r);
                        if (!mem_valid_out) begin
                            err_cnt_r <= sat_inc(err_cnt_r);
                        end
                        state_r       <= ST_RESP;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - 2'd1;
                    end
                end
                ST_RESP: begin
                    a_rsp_valid_r <= 1'b0;
                    b_rsp_valid_r <= 1'b0;
                    a_rsp_data_r  <= {DATA_W{1'b0}};
                    b_rsp_data_r  <= {DATA_W{1'b0}};
                    a_rsp_err_r   <= 1'b0;
                    b_rsp_err_r   <= 1'b0;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign a_req_ready = grant_a_s;
    assign b_req_ready = grant_b_s;
    assign a_rsp_valid = a_rsp_valid_r;
    assign a_rsp_data  = a_rsp_data_r;
    assign a_rsp_err   = a_rsp_err_r;
    assign b_rsp_valid = b_rsp_valid_r;
    assign b_rsp_data  = b_rsp_data_r;
    assign b_rsp_err   = b_rsp_err_r;
    assign mem_EN      = mem_en_r;
    assign mem_wr_en   = mem_wr_en_r;
    assign mem_rd_en   = mem_rd_en_r;
    assign mem_add     = mem_add_r;
    assign mem_Data_in = mem_data_in_r;
    assign busy        = (state_r != ST_IDLE);
    assign wr_cnt      = wr_cnt_r;
    assign rd_cnt      = rd_cnt_r;
    assign err_cnt     = err_cnt_r;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench: behavioural memory, directed vector table, arbitration,
// reset-abort and saturation sequences, then randomized traffic vs a reference model.
module tb_mem_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req_valid, a_req_ready, a_req_wr, a_rsp_valid, a_rsp_err;
    logic [3:0]  a_req_addr;
    logic [31:0] a_req_wdata, a_rsp_data;
    logic        b_req_valid, b_req_ready, b_req_wr, b_rsp_valid, b_rsp_err;
    logic [3:0]  b_req_addr;
    logic [31:0] b_req_wdata, b_rsp_data;
    logic        mem_EN, mem_wr_en, mem_rd_en, mem_valid_out, busy;
    logic [3:0]  mem_add;
    logic [31:0] mem_Data_in, mem_Data_out;
    logic [7:0]  wr_cnt, rd_cnt, err_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] ref_mem [16];
    bit          ref_wr  [16];
    bit          ref_ptr_b;
    int          ref_wr_cnt, ref_rd_cnt, ref_err_cnt;

    // Behavioural single-port memory
    logic [31:0] mem_arr [16];
    bit          mem_written [16];

    always #5 clk = ~clk;

    mem_access_arbiter dut (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_wr(a_req_wr),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata), .a_rsp_valid(a_rsp_valid),
        .a_rsp_data(a_rsp_data), .a_rsp_err(a_rsp_err),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_wr(b_req_wr),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata), .b_rsp_valid(b_rsp_valid),
        .b_rsp_data(b_rsp_data), .b_rsp_err(b_rsp_err),
        .mem_EN(mem_EN), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_add(mem_add),
        .mem_Data_in(mem_Data_in), .mem_valid_out(mem_valid_out), .mem_Data_out(mem_Data_out),
        .busy(busy), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .err_cnt(err_cnt)
    );

    always @(posedge clk) begin
        if (mem_EN && !mem_wr_en && mem_rd_en) begin
            mem_arr[mem_add]     <= mem_Data_in;
            mem_written[mem_add] <= 1'b1;
        end
        if (mem_EN && mem_wr_en && !mem_rd_en) begin
            mem_Data_out  <= mem_arr[mem_add];
            mem_valid_out <= mem_written[mem_add];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        ref_ptr_b   = 1'b0;
        ref_wr_cnt  = 0;
        ref_rd_cnt  = 0;
        ref_err_cnt = 0;
    endtask

    task automatic sat(inout int c);
        if (c < 255) c = c + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // One arbitrated transaction; use_exp selects table constants over the model.
    task automatic txn(input bit va, input bit vb, input bit wa, input bit wb,
                       input logic [3:0] aa, input logic [3:0] ab,
                       input logic [31:0] da, input logic [31:0] db,
                       input bit use_exp, input logic [31:0] tdata, input bit terr);
        bit          gb, wr, got, eerr;
        logic [3:0]  addr;
        logic [31:0] edata;
        int          k;
        @(negedge clk);
        a_req_valid = va; a_req_wr = wa; a_req_addr = aa; a_req_wdata = da;
        b_req_valid = vb; b_req_wr = wb; b_req_addr = ab; b_req_wdata = db;
        #1;
        gb = (va && vb) ? ref_ptr_b : vb;
        chk("both_ready", {63'd0, a_req_ready & b_req_ready}, 64'd0);
        chk("grant_a", {63'd0, a_req_ready}, {63'd0, ~gb});
        chk("grant_b", {63'd0, b_req_ready}, {63'd0, gb});
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        wr   = gb ? wb : wa;
        addr = gb ? ab : aa;
        ref_ptr_b = ~gb;
        if (wr) begin
            edata = 32'd0; eerr = 1'b0;
            ref_mem[addr] = gb ? db : da;
            ref_wr[addr]  = 1'b1;
            sat(ref_wr_cnt);
        end else begin
            eerr  = ~ref_wr[addr];
            edata = ref_wr[addr] ? ref_mem[addr] : 32'd0;
            sat(ref_rd_cnt);
            if (eerr) sat(ref_err_cnt);
        end
        if (use_exp) begin
            edata = tdata; eerr = terr;
        end
        @(negedge clk);
        chk("cmd_en", {63'd0, mem_EN}, 64'd1);
        chk("cmd_wr_en", {63'd0, mem_wr_en}, {63'd0, ~wr});
        chk("cmd_rd_en", {63'd0, mem_rd_en}, {63'd0, wr});
        chk("cmd_add", {60'd0, mem_add}, {60'd0, addr});
        k = 1; got = 1'b0;
        while (k < 10 && !got) begin
            @(negedge clk);
            k++;
            if (gb ? b_rsp_valid : a_rsp_valid) got = 1'b1;
            if (gb ? a_rsp_valid : b_rsp_valid) chk("wrong_port_rsp", 64'd1, 64'd0);
        end
        chk("rsp_latency", 64'(k), wr ? 64'd2 : 64'd3);
        chk("rsp_data", {32'd0, gb ? b_rsp_data : a_rsp_data}, {32'd0, edata});
        chk("rsp_err", {63'd0, gb ? b_rsp_err : a_rsp_err}, {63'd0, eerr});
        chk("wr_cnt", {56'd0, wr_cnt}, 64'(ref_wr_cnt));
        chk("rd_cnt", {56'd0, rd_cnt}, 64'(ref_rd_cnt));
        chk("err_cnt", {56'd0, err_cnt}, 64'(ref_err_cnt));
    endtask

    typedef struct {
        bit          b_port;
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        bit          exp_err;
    } vec_t;

    vec_t tab [7];

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int gcyc [$];
        bit gport [$];
        tab[0] = '{1'b1, 1'b0, 4'd9, 32'd0,          32'd0,          1'b1};
        tab[1] = '{1'b0, 1'b1, 4'd3, 32'hDEADBEEF,   32'd0,          1'b0};
        tab[2] = '{1'b0, 1'b0, 4'd3, 32'd0,          32'hDEADBEEF,   1'b0};
        tab[3] = '{1'b1, 1'b1, 4'd7, 32'h12345678,   32'd0,          1'b0};
        tab[4] = '{1'b0, 1'b0, 4'd7, 32'd0,          32'h12345678,   1'b0};
        tab[5] = '{1'b1, 1'b0, 4'd3, 32'd0,          32'hDEADBEEF,   1'b0};
        tab[6] = '{1'b0, 1'b0, 4'd0, 32'd0,          32'd0,          1'b1};
        for (int i = 0; i < 16; i++) begin
            mem_written[i] = 1'b0; mem_arr[i] = 32'd0;
            ref_wr[i] = 1'b0; ref_mem[i] = 32'd0;
        end
        mem_Data_out = 32'd0; mem_valid_out = 1'b0;
        rst = 1'b0;
        a_req_valid = 1'b0; a_req_wr = 1'b0; a_req_addr = 4'd0; a_req_wdata = 32'd0;
        b_req_valid = 1'b0; b_req_wr = 1'b0; b_req_addr = 4'd0; b_req_wdata = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_outputs", {24'd0, busy, mem_EN, mem_wr_en, mem_rd_en, mem_add,
            a_rsp_valid, b_rsp_valid, a_rsp_err, b_rsp_err, wr_cnt, rd_cnt, err_cnt}, 64'd0);
        chk("reset_data", {mem_Data_in, a_rsp_data | b_rsp_data}, 64'd0);
        rst = 1'b1;

        // Directed vector table
        for (int i = 0; i < 7; i++) begin
            if (tab[i].b_port)
                txn(1'b0, 1'b1, 1'b0, tab[i].wr, 4'd0, tab[i].addr, 32'd0, tab[i].wdata,
                    1'b1, tab[i].exp_data, tab[i].exp_err);
            else
                txn(1'b1, 1'b0, tab[i].wr, 1'b0, tab[i].addr, 4'd0, tab[i].wdata, 32'd0,
                    1'b1, tab[i].exp_data, tab[i].exp_err);
        end

        // Both ports requesting writes continuously: A first, then alternating
        do_reset();
        @(negedge clk);
        a_req_valid = 1'b1; a_req_wr = 1'b1; a_req_addr = 4'd10; a_req_wdata = 32'hA0A0A0A0;
        b_req_valid = 1'b1; b_req_wr = 1'b1; b_req_addr = 4'd11; b_req_wdata = 32'hB0B0B0B0;
        for (int c = 0; c < 14; c++) begin
            #1;
            chk("arb_both_ready", {63'd0, a_req_ready & b_req_ready}, 64'd0);
            if (a_req_ready || b_req_ready) begin
                gcyc.push_back(c);
                gport.push_back(b_req_ready);
            end
            @(negedge clk);
        end
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("arb_grant_count", 64'(gcyc.size()), 64'd5);
        for (int i = 0; i < gcyc.size(); i++) begin
            chk("arb_grant_cycle", 64'(gcyc[i]), 64'(3 * i));
            chk("arb_grant_port", {63'd0, gport[i]}, 64'(i % 2));
        end
        ref_mem[10] = 32'hA0A0A0A0; ref_wr[10] = 1'b1;
        ref_mem[11] = 32'hB0B0B0B0; ref_wr[11] = 1'b1;
        ref_wr_cnt = 5; ref_ptr_b = 1'b1;
        chk("arb_wr_cnt", {56'd0, wr_cnt}, 64'd5);

        // Reset during CAPT of a read discards it; next grant goes to A
        @(negedge clk);
        a_req_valid = 1'b1; a_req_wr = 1'b0; a_req_addr = 4'd3;
        #1;
        chk("abort_ready", {63'd0, a_req_ready}, 64'd1);
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy_capt", {63'd0, busy}, 64'd1);
        rst = 1'b0;
        #1;
        chk("abort_outputs", {24'd0, busy, mem_EN, mem_wr_en, mem_rd_en, mem_add,
            a_rsp_valid, b_rsp_valid, a_rsp_err, b_rsp_err, wr_cnt, rd_cnt, err_cnt}, 64'd0);
        chk("abort_data", {mem_Data_in, a_rsp_data | b_rsp_data}, 64'd0);
        #2;
        rst = 1'b1;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort_no_rsp", {62'd0, a_rsp_valid, b_rsp_valid}, 64'd0);
        end
        txn(1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 4'd6, 32'h55555555, 32'h66666666, 1'b0, 32'd0, 1'b0);

        // Counter saturation
        do_reset();
        for (int i = 0; i < 300; i++)
            txn(1'b1, 1'b0, 1'b1, 1'b0, 4'($urandom_range(0, 15)), 4'd0, $urandom, 32'd0,
                1'b0, 32'd0, 1'b0);
        chk("wr_cnt_saturated", {56'd0, wr_cnt}, 64'd255);

        // Randomized traffic against the reference model
        for (int i = 0; i < 80; i++) begin
            bit va, vb;
            va = 1'($urandom_range(0, 1));
            vb = 1'($urandom_range(0, 1));
            if (!va && !vb) va = 1'b1;
            txn(va, vb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom, $urandom,
                1'b0, 32'd0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
